// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: parametrised full-duplex SPI slave with configurable mode, bit order, width and tx holding register
module spi_slave_cfg #(
  parameter int WIDTH = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_IDLE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             sot,
  output logic             eot,
  output logic             frame_err,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             tx_underrun
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, LOCKOUT} state_t;
  state_t state_q, state_d;
  logic sclk_s, ss_s, mosi_s, ss_all;
  logic sclk_prev_q;
  logic [CW-1:0] bitcnt_q, bitcnt_d, txcnt_q, txcnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d, tx_sr_q, tx_sr_d, hold_q, hold_d, rx_next;
  logic first_q, first_d, primed_q, primed_d, tx_ready_q, tx_ready_d;
  logic rx_valid_q, rx_valid_d, sot_q, sot_d, eot_q, eot_d, ferr_q, ferr_d, under_q, under_d;
  logic act, edge_s, lead, trail, samp, shft, fall, rise, last, reload, full, xfer, take;
  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
    always_ff @(posedge clk)
      if (rst) begin
        sclk_q <= {SYNC_STAGES{CPOL}};
        ss_q <= '1;
        mosi_q <= '0;
      end else begin
        sclk_q <= SYNC_STAGES'({sclk_q, sclk});
        ss_q <= SYNC_STAGES'({ss_q, ss});
        mosi_q <= SYNC_STAGES'({mosi_q, mosi});
      end
    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign ss_s = ss_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign ss_all = &{ss_q, ss};
  end else begin : g_raw
    assign sclk_s = sclk;
    assign ss_s = ss;
    assign mosi_s = mosi;
    assign ss_all = ss;
  end
  always_comb begin
    act = state_q == ACTIVE && !ss_s;
    edge_s = sclk_s != sclk_prev_q;
    lead = edge_s && sclk_s != CPOL;
    trail = edge_s && sclk_s == CPOL;
    samp = act && (CPHA ? trail : lead);
    shft = act && (CPHA ? lead : trail);
    fall = state_q == IDLE && !ss_s;
    rise = state_q == ACTIVE && ss_s;
    last = bitcnt_q == CW'(WIDTH - 1);
    reload = fall || (shft && primed_q && txcnt_q == CW'(WIDTH - 1));
    full = !tx_ready_q;
    xfer = reload && full;
    take = tx_load && (tx_ready_q || xfer);
    rx_next = LSB_FIRST ? {mosi_s, rx_sr_q[WIDTH-1:1]} : {rx_sr_q[WIDTH-2:0], mosi_s};
    state_d = fall ? ACTIVE : rise ? IDLE : (state_q == LOCKOUT && ss_all) ? IDLE : state_q;
    bitcnt_d = (fall || rise) ? '0 : samp ? (last ? '0 : bitcnt_q + 1'b1) : bitcnt_q;
    rx_sr_d = samp ? rx_next : rx_sr_q;
    rx_valid_d = samp && last;
    rx_data_d = rx_valid_d ? rx_next : rx_data_q;
    sot_d = rx_valid_d && first_q;
    first_d = fall ? 1'b1 : rx_valid_d ? 1'b0 : first_q;
    eot_d = rise;
    ferr_d = rise && bitcnt_q != '0;
    hold_d = take ? tx_data : hold_q;
    tx_ready_d = !((full && !xfer) || take);
    under_d = reload && !full;
    tx_sr_d = reload ? (full ? hold_q : TX_IDLE) : (shft && primed_q) ? (LSB_FIRST ? tx_sr_q >> 1 : tx_sr_q << 1) : tx_sr_q;
    txcnt_d = reload ? '0 : (shft && primed_q) ? txcnt_q + 1'b1 : txcnt_q;
    primed_d = fall ? !CPHA : shft ? 1'b1 : primed_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= LOCKOUT;
      sclk_prev_q <= CPOL;
      bitcnt_q <= '0;
      txcnt_q <= '0;
      rx_sr_q <= '0;
      rx_data_q <= '0;
      tx_sr_q <= '0;
      hold_q <= '0;
      first_q <= 1'b0;
      primed_q <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      sot_q <= 1'b0;
      eot_q <= 1'b0;
      ferr_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_prev_q <= sclk_s;
      bitcnt_q <= bitcnt_d;
      txcnt_q <= txcnt_d;
      rx_sr_q <= rx_sr_d;
      rx_data_q <= rx_data_d;
      tx_sr_q <= tx_sr_d;
      hold_q <= hold_d;
      first_q <= first_d;
      primed_q <= primed_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      sot_q <= sot_d;
      eot_q <= eot_d;
      ferr_q <= ferr_d;
      under_q <= under_d;
    end
  assign miso = act && primed_q ? (LSB_FIRST ? tx_sr_q[0] : tx_sr_q[WIDTH-1]) : 1'b0;
  assign miso_oe = !ss_s;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sot = sot_q;
  assign eot = eot_q;
  assign frame_err = ferr_q;
  assign tx_ready = tx_ready_q;
  assign tx_underrun = under_q;
endmodule

// File: tb/tb_spi_slave_cfg.sv
// tb_spi_slave_cfg: directed checks of a mode-0 8-bit instance and a mode-3 16-bit LSB-first instance
module tb_spi_slave_cfg;
  logic clk = 1'b0, rst = 1'b1;
  logic sclk0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b0;
  logic miso0, oe0, rv0, sot0, eot0, ferr0, rdy0, und0;
  logic [7:0] rd0;
  logic sclk1 = 1'b1, ss1 = 1'b1, mosi1 = 1'b0, load1 = 1'b0;
  logic [15:0] td1 = '0, rd1;
  logic miso1, oe1, rv1, sot1, eot1, ferr1, rdy1, und1;
  int n_chk = 0, n_err = 0;
  logic [7:0] rx0_q[$];
  logic sot0_q[$];
  logic [15:0] rx1_q[$];
  int eot0_n = 0, ferr0_n = 0, ferr_eot0_n = 0, und1_n = 0, busy1_n = 0;
  always #5 clk = ~clk;
  spi_slave_cfg #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0), .SYNC_STAGES(0)) u0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss(ss0), .mosi(mosi0), .miso(miso0), .miso_oe(oe0),
    .rx_data(rd0), .rx_valid(rv0), .sot(sot0), .eot(eot0), .frame_err(ferr0),
    .tx_data(8'h00), .tx_load(1'b0), .tx_ready(rdy0), .tx_underrun(und0));
  spi_slave_cfg #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(miso1), .miso_oe(oe1),
    .rx_data(rd1), .rx_valid(rv1), .sot(sot1), .eot(eot1), .frame_err(ferr1),
    .tx_data(td1), .tx_load(load1), .tx_ready(rdy1), .tx_underrun(und1));
  always @(negedge clk) begin
    if (rv0) begin
      rx0_q.push_back(rd0);
      sot0_q.push_back(sot0);
    end
    if (eot0) eot0_n++;
    if (ferr0) ferr0_n++;
    if (ferr0 && eot0) ferr_eot0_n++;
    if (rv1) rx1_q.push_back(rd1);
    if (und1) und1_n++;
    if (!rdy1) busy1_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bit0(input logic b);
    mosi0 = b;
    tick(1);
    sclk0 = 1'b1;
    tick(1);
    sclk0 = 1'b0;
    tick(1);
  endtask
  task automatic word0(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bit0(w[i]);
  endtask
  task automatic word1(input logic [15:0] w, output logic [15:0] m);
    for (int i = 0; i < 16; i++) begin
      sclk1 = 1'b0;
      mosi1 = w[i];
      tick(4);
      m[i] = miso1;
      sclk1 = 1'b1;
      tick(4);
    end
  endtask
  task automatic clr();
    rx0_q.delete();
    sot0_q.delete();
    rx1_q.delete();
    eot0_n = 0;
    ferr0_n = 0;
    ferr_eot0_n = 0;
    und1_n = 0;
    busy1_n = 0;
  endtask
  initial begin
    logic [15:0] m1, m2;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_rd0", rd0, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_rdy0", rdy0, 1);
    chk("rst_eot0", eot0, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_rdy1", rdy1, 1);
    chk("rst_miso1", miso1, 0);
    chk("rst_oe1", oe1, 0);
    tick(3);
    clr();
    ss0 = 1'b0;
    tick(2);
    word0(8'hFF);
    tick(1);
    ss0 = 1'b1;
    tick(2);
    chk("t1_n", rx0_q.size(), 1);
    chk("t1_data", rx0_q.size() > 0 ? rx0_q[0] : 8'h00, 8'hFF);
    chk("t1_sot", sot0_q.size() > 0 ? sot0_q[0] : 1'b0, 1);
    chk("t1_eot", eot0_n, 1);
    chk("t1_ferr", ferr0_n, 0);
    chk("t1_sot_idle", sot0, 0);
    clr();
    ss0 = 1'b0;
    tick(2);
    for (int w = 0; w < 4; w++) word0(8'(w));
    tick(1);
    ss0 = 1'b1;
    tick(2);
    chk("t2_n", rx0_q.size(), 4);
    for (int w = 0; w < 4; w++) begin
      chk("t2_data", w < rx0_q.size() ? rx0_q[w] : 8'hEE, w);
      chk("t2_sot", w < sot0_q.size() ? sot0_q[w] : 1'bx, w == 0);
    end
    chk("t2_eot", eot0_n, 1);
    clr();
    td1 = 16'hA55A;
    load1 = 1'b1;
    tick(1);
    load1 = 1'b0;
    tick(1);
    chk("t3_busy", rdy1, 0);
    ss1 = 1'b0;
    tick(4);
    chk("t3_oe", oe1, 1);
    word1(16'h1234, m1);
    tick(2);
    ss1 = 1'b1;
    tick(4);
    chk("t3_miso", m1, 16'hA55A);
    chk("t3_n", rx1_q.size(), 1);
    chk("t3_data", rx1_q.size() > 0 ? rx1_q[0] : 16'h0, 16'h1234);
    chk("t3_und", und1_n, 0);
    chk("t3_rdy", rdy1, 1);
    clr();
    ss1 = 1'b0;
    tick(4);
    word1(16'h00FF, m1);
    word1(16'hF00F, m2);
    tick(2);
    ss1 = 1'b1;
    tick(4);
    chk("t4_miso_a", m1, 16'hFFFF);
    chk("t4_miso_b", m2, 16'hFFFF);
    chk("t4_und", und1_n, 2);
    chk("t4_busy", busy1_n, 0);
    chk("t4_n", rx1_q.size(), 2);
    chk("t4_data_b", rx1_q.size() > 1 ? rx1_q[1] : 16'h0, 16'hF00F);
    clr();
    td1 = 16'h1111;
    load1 = 1'b1;
    tick(1);
    td1 = 16'h2222;
    tick(1);
    load1 = 1'b0;
    ss1 = 1'b0;
    tick(4);
    word1(16'h0F0F, m1);
    tick(2);
    ss1 = 1'b1;
    tick(4);
    chk("t4b_miso", m1, 16'h1111);
    chk("t4b_und", und1_n, 0);
    chk("t4b_rdy", rdy1, 1);
    clr();
    ss0 = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) bit0(1'b1);
    ss0 = 1'b1;
    tick(2);
    chk("t5_eot", eot0_n, 1);
    chk("t5_ferr", ferr_eot0_n, 1);
    chk("t5_ferr_only", ferr0_n, 1);
    chk("t5_nrx", rx0_q.size(), 0);
    ss0 = 1'b0;
    tick(2);
    word0(8'hA5);
    tick(1);
    ss0 = 1'b1;
    tick(2);
    chk("t5_n", rx0_q.size(), 1);
    chk("t5_data", rx0_q.size() > 0 ? rx0_q[0] : 8'h00, 8'hA5);
    clr();
    ss0 = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) bit0(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_rd", rd0, 0);
    chk("t6_rdy", rdy0, 1);
    chk("t6_miso", miso0, 0);
    for (int i = 0; i < 4; i++) bit0(1'b0);
    chk("t6_nrx", rx0_q.size(), 0);
    ss0 = 1'b1;
    tick(2);
    ss0 = 1'b0;
    tick(2);
    word0(8'h3C);
    tick(1);
    ss0 = 1'b1;
    tick(2);
    chk("t6_n", rx0_q.size(), 1);
    chk("t6_data", rx0_q.size() > 0 ? rx0_q[0] : 8'h00, 8'h3C);
    chk("t6_sot", sot0_q.size() > 0 ? sot0_q[0] : 1'b0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
